// File: rtl/uart_tx_arbiter_if.sv
// Bundle between uart_tx_arbiter, its two word requesters and the byte UART.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if #(
    parameter int WORD_BYTES = 4
);
    logic                    req0;
    logic [8*WORD_BYTES-1:0] data0;
    logic                    ack0;
    logic                    req1;
    logic [8*WORD_BYTES-1:0] data1;
    logic                    ack1;
    logic [7:0]              tx_din;
    logic                    tx_wr_en;
    logic                    tx_busy;
    logic                    busy;
    logic                    grant;

    modport slave (
        input  req0, data0, req1, data1, tx_busy,
        output ack0, ack1, tx_din, tx_wr_en, busy, grant
    );

    modport master (
        output req0, data0, req1, data1, tx_busy,
        input  ack0, ack1, tx_din, tx_wr_en, busy, grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes two requesters' words MSB byte first onto a byte UART.
// Define UART_TX_TAG_EN to prefix every word with a source tag byte (A0/A1).
module uart_tx_arbiter #(
    parameter int WORD_BYTES = 4
) (
    input logic              clock,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

`ifdef UART_TX_TAG_EN
    localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
    localparam int FRAME_BYTES = WORD_BYTES;
`endif
    localparam int SHIFT_W = 8 * FRAME_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ARM,
        ST_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [7:0]              tx_din_q, tx_din_d;
    logic                    tx_wr_en_q, tx_wr_en_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    busy_q, busy_d;
    logic                    grant_q, grant_d;

    logic                    any_req;
    logic                    sel;
    logic [8*WORD_BYTES-1:0] sel_data;

    // On a tie the source that did not win last time is picked.
    assign any_req  = bus.req0 | bus.req1;
    assign sel      = (bus.req0 & bus.req1) ? ~grant_q : bus.req1;
    assign sel_data = sel ? bus.data1 : bus.data0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_din_q   <= '0;
            tx_wr_en_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)      state_d = ST_SEND;
            ST_SEND: if (!bus.tx_busy) state_d = ST_ARM;
            ST_ARM:                    state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.tx_busy) begin
                    state_d = (cnt_q != 5'd0) ? ST_SEND : ST_IDLE;
                end
            end
            default:                   state_d = ST_IDLE;
        endcase
    end

    // ARM exists only to give the UART one cycle to raise tx_busy before WAIT samples it.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_din_d   = tx_din_q;
        tx_wr_en_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        grant_d    = grant_q;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
`ifdef UART_TX_TAG_EN
                    shift_d = {7'b1010000, sel, sel_data};
`else
                    shift_d = sel_data;
`endif
                    grant_d = sel;
                    ack0_d  = ~sel;
                    ack1_d  = sel;
                    cnt_d   = 5'(FRAME_BYTES);
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    tx_wr_en_d = 1'b1;
                    tx_din_d   = shift_q[SHIFT_W-1 -: 8];
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.tx_busy && (cnt_q != 5'd0)) begin
                    shift_d = shift_q << 8;
                end
            end
            default: ;
        endcase
    end

    assign bus.tx_din   = tx_din_q;
    assign bus.tx_wr_en = tx_wr_en_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a byte-UART model plus a word-level reference
// model of arbitration order and expected byte stream (tag bytes when UART_TX_TAG_EN).
module tb_uart_tx_arbiter;

    localparam int WB = 4;
    localparam int DW = 8 * WB;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.WORD_BYTES(WB)) bus ();

    uart_tx_arbiter #(.WORD_BYTES(WB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // UART model: busy for busy_len cycles after each strobe; hold_busy forces it high.
    int   busy_len  = 10;
    logic hold_busy = 1'b0;
    int   uart_cnt  = 0;
    assign bus.tx_busy = hold_busy || (uart_cnt != 0);

    always @(posedge clock) begin
        if (bus.tx_wr_en === 1'b1) uart_cnt <= busy_len;
        else if (uart_cnt != 0)    uart_cnt <= uart_cnt - 1;
    end

    // Event log sampled on the falling edge.
    logic [7:0] seen_bytes[$];
    bit         strobe_busy[$];
    int         ack_src[$];
    int         ack_grant[$];
    int         txb_falls[$];
    int         busy_falls[$];
    int         cyc      = 0;
    logic       prev_txb = 1'b0;
    logic       prev_bsy = 1'b0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (bus.tx_wr_en === 1'b1) begin
            seen_bytes.push_back(bus.tx_din);
            strobe_busy.push_back(bus.tx_busy);
        end
        if (bus.ack0 === 1'b1) begin
            ack_src.push_back(0);
            ack_grant.push_back(int'(bus.grant));
        end
        if (bus.ack1 === 1'b1) begin
            ack_src.push_back(1);
            ack_grant.push_back(int'(bus.grant));
        end
        if (prev_txb && !bus.tx_busy) txb_falls.push_back(cyc);
        if (prev_bsy && !bus.busy)    busy_falls.push_back(cyc);
        prev_txb <= bus.tx_busy;
        prev_bsy <= bus.busy;
    end

    // Reference model: word order and the byte stream each word must produce.
    logic [7:0] exp_bytes[$];
    int         exp_src[$];
    int         model_last = 1;

    task automatic model_word(input int src, input logic [DW-1:0] d);
`ifdef UART_TX_TAG_EN
        exp_bytes.push_back(src == 1 ? 8'hA1 : 8'hA0);
`endif
        for (int i = WB - 1; i >= 0; i--) exp_bytes.push_back(d[8*i +: 8]);
        exp_src.push_back(src);
        model_last = src;
    endtask

    task automatic model_requests(input bit r0, input bit r1,
                                  input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        if (r0 && r1) begin
            if (model_last == 1) begin
                model_word(0, d0);
                model_word(1, d1);
            end else begin
                model_word(1, d1);
                model_word(0, d0);
            end
        end else if (r0) begin
            model_word(0, d0);
        end else if (r1) begin
            model_word(1, d1);
        end
    endtask

    function automatic string fmt_bytes(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
        return s;
    endfunction

    function automatic string fmt_ints(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    function automatic int count_busy_strobes();
        int n = 0;
        foreach (strobe_busy[i]) if (strobe_busy[i]) n++;
        return n;
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_logs();
        seen_bytes.delete();
        strobe_busy.delete();
        ack_src.delete();
        ack_grant.delete();
        txb_falls.delete();
        busy_falls.delete();
        exp_bytes.delete();
        exp_src.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_last = 1;
        step();
    endtask

    // Plays both requesters (drop req on ack) until everything is quiet.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
            if (bus.ack1 === 1'b1) bus.req1 = 1'b0;
            if (!bus.req0 && !bus.req1 && bus.busy === 1'b0 && !bus.tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        n_vectors += 6;
        if (bus.tx_din !== 8'h00) begin n_miscompares++; $display("[TB] FAIL reset_tx_din: got %h expected 00", bus.tx_din); end
        if (bus.tx_wr_en !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.tx_wr_en); end
        if (bus.ack0 !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_ack0: got %b expected 0", bus.ack0); end
        if (bus.ack1 !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_ack1: got %b expected 0", bus.ack1); end
        if (bus.busy !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.grant !== 1'b1) begin n_miscompares++; $display("[TB] FAIL reset_grant: got %b expected 1", bus.grant); end
        reset = 1'b1;
        model_last = 1;
        step();
    endtask

    task automatic test_single_word();
        bit ok;
        clear_logs();
        busy_len = 10;
        model_word(0, 32'h12345678);
        bus.data0 = 32'h12345678;
        bus.req0  = 1'b1;
        step();
        n_vectors += 2;
        if (bus.ack0 !== 1'b1) begin n_miscompares++; $display("[TB] FAIL single_ack_latency: got %b expected 1", bus.ack0); end
        if (bus.busy !== 1'b1) begin n_miscompares++; $display("[TB] FAIL single_busy_rise: got %b expected 1", bus.busy); end
        bus.req0 = 1'b0;
        step();
        n_vectors++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_din !== exp_bytes[0]) begin
            n_miscompares++;
            $display("[TB] FAIL single_first_strobe: got wr_en=%b din=%h expected wr_en=1 din=%h", bus.tx_wr_en, bus.tx_din, exp_bytes[0]);
        end
        wait_done(ok);
        n_vectors += 4;
        if (!ok) begin n_miscompares++; $display("[TB] FAIL single_timeout: got no idle expected idle"); end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL single_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
        if (fmt_ints(ack_src) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL single_acks: got %s expected %s", fmt_ints(ack_src), fmt_ints(exp_src));
        end
        if (busy_falls.size() != 1 || txb_falls.size() == 0 || busy_falls[0] != txb_falls[txb_falls.size()-1] + 1) begin
            n_miscompares++;
            $display("[TB] FAIL single_busy_fall: got %0d busy falls expected one busy fall one cycle after last tx_busy fall", busy_falls.size());
        end
    endtask

    task automatic test_tie_after_reset();
        bit ok;
        logic [DW-1:0] d0;
        apply_reset();
        clear_logs();
        busy_len = $urandom_range(2, 8);
        d0 = $urandom;
        model_requests(1'b1, 1'b1, d0, 32'hDEADBEEF);
        bus.data0 = d0;
        bus.data1 = 32'hDEADBEEF;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        wait_done(ok);
        n_vectors += 4;
        if (!ok) begin n_miscompares++; $display("[TB] FAIL tie_timeout: got no idle expected idle"); end
        if (fmt_ints(ack_src) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL tie_order: got %s expected %s", fmt_ints(ack_src), fmt_ints(exp_src));
        end
        if (fmt_ints(ack_grant) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL tie_grant: got %s expected %s", fmt_ints(ack_grant), fmt_ints(exp_src));
        end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL tie_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] d0, d1;
        clear_logs();
        busy_len = $urandom_range(1, 6);
        for (int r = 0; r < 2; r++) begin
            d0 = $urandom;
            d1 = $urandom;
            model_requests(1'b1, 1'b1, d0, d1);
            bus.data0 = d0;
            bus.data1 = d1;
            bus.req0  = 1'b1;
            bus.req1  = 1'b1;
            wait_done(ok);
            n_vectors++;
            if (!ok) begin n_miscompares++; $display("[TB] FAIL b2b_timeout: got no idle in round %0d expected idle", r); end
        end
        n_vectors += 4;
        if (fmt_ints(ack_src) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL b2b_order: got %s expected %s", fmt_ints(ack_src), fmt_ints(exp_src));
        end
        if (fmt_ints(ack_grant) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL b2b_grant: got %s expected %s", fmt_ints(ack_grant), fmt_ints(exp_src));
        end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL b2b_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
        if (count_busy_strobes() != 0) begin
            n_miscompares++; $display("[TB] FAIL b2b_strobe_while_busy: got %0d expected 0", count_busy_strobes());
        end
    endtask

    task automatic test_tag_word();
        bit ok;
        clear_logs();
        busy_len = 4;
        model_word(1, 32'h00000001);
        bus.data1 = 32'h00000001;
        bus.req1  = 1'b1;
        wait_done(ok);
        n_vectors += 2;
        if (!ok) begin n_miscompares++; $display("[TB] FAIL tag_timeout: got no idle expected idle"); end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL tag_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
    endtask

    task automatic test_random();
        bit ok;
        int pattern;
        logic [DW-1:0] d0, d1;
        for (int r = 0; r < 8; r++) begin
            clear_logs();
            busy_len = $urandom_range(1, 12);
            pattern  = $urandom_range(1, 3);
            d0 = $urandom;
            d1 = $urandom;
            model_requests(pattern[0], pattern[1], d0, d1);
            bus.data0 = d0;
            bus.data1 = d1;
            bus.req0  = pattern[0];
            bus.req1  = pattern[1];
            wait_done(ok);
            n_vectors += 4;
            if (!ok) begin n_miscompares++; $display("[TB] FAIL rand_timeout: got no idle in round %0d expected idle", r); end
            if (fmt_ints(ack_src) != fmt_ints(exp_src)) begin
                n_miscompares++; $display("[TB] FAIL rand_order[%0d]: got %s expected %s", r, fmt_ints(ack_src), fmt_ints(exp_src));
            end
            if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
                n_miscompares++; $display("[TB] FAIL rand_bytes[%0d]: got %s expected %s", r, fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
            end
            if (count_busy_strobes() != 0) begin
                n_miscompares++; $display("[TB] FAIL rand_strobe_while_busy[%0d]: got %0d expected 0", r, count_busy_strobes());
            end
        end
    endtask

    task automatic test_busy_stall();
        bit ok;
        logic [DW-1:0] d1;
        clear_logs();
        busy_len  = 5;
        hold_busy = 1'b1;
        d1 = $urandom;
        model_word(1, d1);
        bus.data1 = d1;
        bus.req1  = 1'b1;
        step();
        n_vectors++;
        if (bus.ack1 !== 1'b1) begin n_miscompares++; $display("[TB] FAIL stall_ack1: got %b expected 1", bus.ack1); end
        bus.req1 = 1'b0;
        for (int i = 0; i < 100; i++) step();
        n_vectors += 2;
        if (seen_bytes.size() != 0) begin n_miscompares++; $display("[TB] FAIL stall_hold: got %0d strobes expected 0", seen_bytes.size()); end
        if (bus.busy !== 1'b1) begin n_miscompares++; $display("[TB] FAIL stall_busy: got %b expected 1", bus.busy); end
        hold_busy = 1'b0;
        step();
        n_vectors++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_din !== exp_bytes[0]) begin
            n_miscompares++;
            $display("[TB] FAIL stall_release_strobe: got wr_en=%b din=%h expected wr_en=1 din=%h", bus.tx_wr_en, bus.tx_din, exp_bytes[0]);
        end
        wait_done(ok);
        n_vectors += 2;
        if (!ok) begin n_miscompares++; $display("[TB] FAIL stall_timeout: got no idle expected idle"); end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL stall_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        bit found;
        logic [DW-1:0] da, db;
        clear_logs();
        busy_len = 10;
        da = $urandom;
        db = $urandom;
        model_word(0, da);
        while (exp_bytes.size() > 2) void'(exp_bytes.pop_back());
        bus.data0 = da;
        bus.req0  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
            if (seen_bytes.size() >= 2) begin
                found = 1'b1;
                break;
            end
        end
        n_vectors++;
        if (!found) begin n_miscompares++; $display("[TB] FAIL midrst_second_strobe: got %0d strobes expected 2", seen_bytes.size()); end
        bus.req0 = 1'b0;
        step();
        reset = 1'b0;
        model_last = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vectors += 3;
            if (bus.tx_din !== 8'h00 || bus.tx_wr_en !== 1'b0) begin
                n_miscompares++; $display("[TB] FAIL midrst_tx: got din=%h wr_en=%b expected din=00 wr_en=0", bus.tx_din, bus.tx_wr_en);
            end
            if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) begin
                n_miscompares++; $display("[TB] FAIL midrst_ctrl: got ack0=%b ack1=%b busy=%b expected 0 0 0", bus.ack0, bus.ack1, bus.busy);
            end
            if (bus.grant !== 1'b1) begin n_miscompares++; $display("[TB] FAIL midrst_grant: got %b expected 1", bus.grant); end
        end
        reset = 1'b1;
        model_word(0, db);
        bus.data0 = db;
        bus.req0  = 1'b1;
        n_vectors++;
        if (bus.tx_busy !== 1'b1) begin n_miscompares++; $display("[TB] FAIL midrst_uart_still_busy: got %b expected 1", bus.tx_busy); end
        wait_done(ok);
        n_vectors += 4;
        if (!ok) begin n_miscompares++; $display("[TB] FAIL midrst_timeout: got no idle expected idle"); end
        if (fmt_bytes(seen_bytes) != fmt_bytes(exp_bytes)) begin
            n_miscompares++; $display("[TB] FAIL midrst_bytes: got %s expected %s", fmt_bytes(seen_bytes), fmt_bytes(exp_bytes));
        end
        if (fmt_ints(ack_grant) != fmt_ints(exp_src)) begin
            n_miscompares++; $display("[TB] FAIL midrst_grant_log: got %s expected %s", fmt_ints(ack_grant), fmt_ints(exp_src));
        end
        if (count_busy_strobes() != 0) begin
            n_miscompares++; $display("[TB] FAIL midrst_strobe_while_busy: got %0d expected 0", count_busy_strobes());
        end
    endtask

    initial begin
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        test_reset();
        test_single_word();
        test_tie_after_reset();
        test_back_to_back();
        test_tag_word();
        test_random();
        test_busy_stall();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
